// File: rtl/sle_pkg.sv
// Shared definitions for the SLE shift-bank family: mode encodings and width helpers.
package sle_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_SHIFT = 2'b01,
      MODE_RSVD  = 2'b10,
      MODE_ROT   = 2'b11
   } sle_mode_e;

   // Tap select needs at least one bit even when clog2 collapses to zero.
   function automatic int tap_w(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sle_stage.sv
// One WIDTH-bit SLE-style storage stage: synchronous reset, enable, sync load and next-data update.
module sle_stage #(
   parameter int              WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sln,
   input  logic             upd,
   input  logic [WIDTH-1:0] sd,
   input  logic [WIDTH-1:0] nxt,
   output logic [WIDTH-1:0] q
);

   // Priority: reset, then enable gating, then sync load, then shift/rotate update.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= RESET_VAL;
      end else if (en) begin
         if (!sln) begin
            q <= sd;
         end else if (upd) begin
            q <= nxt;
         end
      end
   end

endmodule

// File: rtl/sle_shift_bank.sv
// DEPTH-stage SLE shift/rotate bank with fill counter, selectable tap and latch-style bypass.
module sle_shift_bank
   import sle_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              TAP_W     = tap_w(DEPTH),
   localparam int              CNT_W     = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sln,
   input  logic [WIDTH-1:0] sd,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       mode,
   input  logic             lat,
   input  logic [TAP_W-1:0] tap_sel,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_tap,
   output logic [CNT_W-1:0] cnt,
   output logic             full
);

   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEPTH);
   localparam logic [TAP_W:0]   DEPTH_TAP = (TAP_W + 1)'(DEPTH);

   logic [WIDTH-1:0] stage [DEPTH];
   logic             shift_op;
   logic             rot_op;

   assign shift_op = (mode == MODE_SHIFT);
   assign rot_op   = (mode == MODE_ROT);

   // Stage 0 takes serial data on shift and the last stage on rotate; the rest chain.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] nxt;

      if (i == 0) begin : g_head
         assign nxt = rot_op ? stage[DEPTH-1] : d;
      end else begin : g_body
         assign nxt = stage[i-1];
      end

      sle_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .sln   (sln),
         .upd   (shift_op | rot_op),
         .sd    (sd),
         .nxt   (nxt),
         .q     (stage[i])
      );
   end

   // Fill level saturates at DEPTH; rotate leaves it alone since no data enters or leaves.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         if (!sln) begin
            cnt <= CNT_MAX;
         end else if (shift_op && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign full = (cnt == CNT_MAX);
   assign q    = lat ? d : stage[DEPTH-1];

   always_comb begin
      q_tap = '0;
      if ({1'b0, tap_sel} < DEPTH_TAP) begin
         q_tap = stage[tap_sel];
      end
   end

endmodule

// File: tb/tb_sle_shift_bank.sv
// Self-checking bench for sle_shift_bank: vector table through a scoreboard queue plus corner sequences.
module tb_sle_shift_bank;

   typedef struct {
      logic       rst_n;
      logic       en;
      logic       sln;
      logic [1:0] mode;
      logic [7:0] d;
      logic [7:0] sd;
      logic       lat;
      logic [1:0] tap;
      logic [7:0] q;
      logic [7:0] q_tap;
      logic [2:0] cnt;
      logic       full;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n, en, sln, lat;
   logic [7:0] sd, d;
   logic [1:0] mode;
   logic [1:0] tap_sel;
   logic [7:0] q, q_tap;
   logic [2:0] cnt;
   logic       full;

   logic [1:0] tap_sel3;
   logic [7:0] q3, q_tap3;
   logic [1:0] cnt3;
   logic       full3;

   int checks = 0;
   int errors = 0;

   vec_t tbl[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   sle_shift_bank #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sln(sln), .sd(sd), .d(d), .mode(mode),
      .lat(lat), .tap_sel(tap_sel), .q(q), .q_tap(q_tap), .cnt(cnt), .full(full)
   );

   // Three-deep build shares the stimulus; used for out-of-range tap checks.
   sle_shift_bank #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut3 (
      .clk(clk), .rst_n(rst_n), .en(en), .sln(sln), .sd(sd), .d(d), .mode(mode),
      .lat(lat), .tap_sel(tap_sel3), .q(q3), .q_tap(q_tap3), .cnt(cnt3), .full(full3)
   );

   function automatic vec_t mk(input logic r, input logic e, input logic s, input logic [1:0] m,
                               input logic [7:0] dd, input logic [7:0] ss, input logic l,
                               input logic [1:0] t, input logic [7:0] eq, input logic [7:0] et,
                               input logic [2:0] ec, input logic ef);
      vec_t v;
      v.rst_n = r; v.en = e; v.sln = s; v.mode = m; v.d = dd; v.sd = ss; v.lat = l; v.tap = t;
      v.q = eq; v.q_tap = et; v.cnt = ec; v.full = ef;
      return v;
   endfunction

   task automatic apply_stimulus(input vec_t v);
      rst_n   = v.rst_n;
      en      = v.en;
      sln     = v.sln;
      mode    = v.mode;
      d       = v.d;
      sd      = v.sd;
      lat     = v.lat;
      tap_sel = v.tap;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   initial begin
      vec_t e;
      rst_n = 1'b0; en = 1'b1; sln = 1'b1; mode = 2'b01; d = 8'hAA; sd = 8'h00;
      lat = 1'b0; tap_sel = 2'd0; tap_sel3 = 2'd0;

      //         rst en sln mode   d      sd     lat tap    q      q_tap  cnt full
      tbl.push_back(mk(0, 1, 1, 2'b01, 8'hAA, 8'h00, 0, 2'd0, 8'h00, 8'h00, 3'd0, 0));
      tbl.push_back(mk(0, 1, 1, 2'b01, 8'hAA, 8'h00, 0, 2'd0, 8'h00, 8'h00, 3'd0, 0));
      tbl.push_back(mk(1, 1, 1, 2'b01, 8'h11, 8'h00, 0, 2'd0, 8'h00, 8'h11, 3'd1, 0));
      tbl.push_back(mk(1, 1, 1, 2'b01, 8'h22, 8'h00, 0, 2'd0, 8'h00, 8'h22, 3'd2, 0));
      tbl.push_back(mk(1, 1, 1, 2'b01, 8'h33, 8'h00, 0, 2'd0, 8'h00, 8'h33, 3'd3, 0));
      tbl.push_back(mk(1, 1, 1, 2'b01, 8'h44, 8'h00, 0, 2'd0, 8'h11, 8'h44, 3'd4, 1));
      tbl.push_back(mk(1, 1, 1, 2'b11, 8'h00, 8'h00, 0, 2'd1, 8'h22, 8'h44, 3'd4, 1));
      tbl.push_back(mk(1, 1, 1, 2'b11, 8'h00, 8'h00, 0, 2'd2, 8'h33, 8'h44, 3'd4, 1));
      tbl.push_back(mk(1, 1, 1, 2'b11, 8'h00, 8'h00, 0, 2'd0, 8'h44, 8'h33, 3'd4, 1));
      tbl.push_back(mk(1, 1, 1, 2'b11, 8'h00, 8'h00, 0, 2'd0, 8'h11, 8'h44, 3'd4, 1));
      tbl.push_back(mk(1, 1, 1, 2'b00, 8'h99, 8'h00, 0, 2'd2, 8'h11, 8'h22, 3'd4, 1));
      tbl.push_back(mk(1, 1, 1, 2'b10, 8'h99, 8'h00, 0, 2'd3, 8'h11, 8'h11, 3'd4, 1));
      tbl.push_back(mk(1, 1, 1, 2'b01, 8'h55, 8'h00, 0, 2'd0, 8'h22, 8'h55, 3'd4, 1));
      tbl.push_back(mk(1, 0, 0, 2'b01, 8'h66, 8'h5A, 0, 2'd0, 8'h22, 8'h55, 3'd4, 1));
      tbl.push_back(mk(1, 1, 0, 2'b01, 8'h66, 8'h5A, 0, 2'd0, 8'h5A, 8'h5A, 3'd4, 1));
      tbl.push_back(mk(1, 0, 1, 2'b01, 8'hC3, 8'h00, 1, 2'd0, 8'hC3, 8'h5A, 3'd4, 1));
      tbl.push_back(mk(1, 1, 1, 2'b01, 8'h77, 8'h00, 1, 2'd0, 8'h77, 8'h77, 3'd4, 1));
      tbl.push_back(mk(1, 0, 1, 2'b01, 8'h77, 8'h00, 0, 2'd0, 8'h5A, 8'h77, 3'd4, 1));
      tbl.push_back(mk(0, 1, 1, 2'b01, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 3'd0, 0));
      tbl.push_back(mk(1, 1, 1, 2'b01, 8'hA1, 8'h00, 0, 2'd0, 8'h00, 8'hA1, 3'd1, 0));
      tbl.push_back(mk(1, 1, 1, 2'b01, 8'hB2, 8'h00, 0, 2'd1, 8'h00, 8'hA1, 3'd2, 0));
      tbl.push_back(mk(0, 1, 0, 2'b01, 8'hB2, 8'hFF, 0, 2'd1, 8'h00, 8'h00, 3'd0, 0));
      tbl.push_back(mk(1, 0, 1, 2'b01, 8'hC4, 8'h00, 0, 2'd0, 8'h00, 8'h00, 3'd0, 0));
      tbl.push_back(mk(1, 1, 1, 2'b11, 8'hC4, 8'h00, 0, 2'd0, 8'h00, 8'h00, 3'd0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         apply_stimulus(tbl[i]);
         sb.push_back(tbl[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check_output($sformatf("vec%0d_q", i), 32'(q), 32'(e.q));
         check_output($sformatf("vec%0d_q_tap", i), 32'(q_tap), 32'(e.q_tap));
         check_output($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(e.cnt));
         check_output($sformatf("vec%0d_full", i), 32'(full), 32'(e.full));
      end

      // Reset must be purely synchronous: a pulse between edges is ignored.
      @(negedge clk);
      rst_n = 1'b1; en = 1'b1; sln = 1'b0; sd = 8'h3C; mode = 2'b00; lat = 1'b0; tap_sel = 2'd0;
      @(posedge clk);
      #1;
      check_output("load_3c_q", 32'(q), 32'h3C);
      check_output("load_3c_cnt", 32'(cnt), 32'd4);
      sln = 1'b1;
      rst_n = 1'b0;
      #2;
      check_output("midcycle_rst_q", 32'(q), 32'h3C);
      check_output("midcycle_rst_cnt", 32'(cnt), 32'd4);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_output("dropped_rst_q", 32'(q), 32'h3C);
      check_output("dropped_rst_full", 32'(full), 32'd1);
      rst_n = 1'b0; mode = 2'b01; d = 8'hAA;
      @(posedge clk);
      #1;
      check_output("rst_edge_q", 32'(q), 32'h00);
      check_output("rst_edge_cnt", 32'(cnt), 32'd0);
      check_output("rst_edge_full", 32'(full), 32'd0);

      // Three-deep build: in-range taps read stages, tap_sel=3 reads zero.
      @(negedge clk);
      rst_n = 1'b1; en = 1'b1; sln = 1'b0; sd = 8'hE7; tap_sel3 = 2'd2;
      @(posedge clk);
      #1;
      check_output("d3_q", 32'(q3), 32'hE7);
      check_output("d3_tap2", 32'(q_tap3), 32'hE7);
      check_output("d3_cnt", 32'(cnt3), 32'd3);
      check_output("d3_full", 32'(full3), 32'd1);
      tap_sel3 = 2'd3;
      #1;
      check_output("d3_tap3_oor", 32'(q_tap3), 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
